// File: rtl/vga_fb_scanout.sv
// Read side of the VGA framebuffer: 640x480@60 timing, one-pixel-ahead fetch, aligned sync/colour outputs.
// Fetch for pixel (x,y) is issued when the counters reach (x,y); the pins show it one pixel period later.
module vga_fb_scanout #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [18:0] rd_addr_o,
    output logic        rd_en_o,
    input  logic [15:0] rd_data_i,
    output logic        vga_hs_o,
    output logic        vga_vs_o,
    output logic [11:0] vga_rgb_o,
    output logic        frame_start_o,
    output logic        vblank_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW      = 10;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0]         div_cnt_q;
    logic [CW-1:0]         hcnt_q;
    logic [CW-1:0]         vcnt_q;
    logic                  run_q;
    logic [18:0]           addr_q;
    logic                  rd_en_q;
    logic [18:0]           rd_addr_q;
    logic [RD_LATENCY-1:0] lat_sr_q;
    logic [11:0]           pix_q;
    logic                  hs_q;
    logic                  vs_q;
    logic [11:0]           rgb_q;
    logic                  frame_start_q;
    logic                  vblank_q;

    logic                  tick;
    logic [CW-1:0]         hcnt_d;
    logic [CW-1:0]         vcnt_d;
    logic                  nxt_active;
    logic [18:0]           fetch_addr;
    logic                  cur_active;
    logic                  cur_origin;
    logic                  cur_hs_low;
    logic                  cur_vs_low;
    logic                  cur_vblank;
    logic                  unused_hi;

    assign unused_hi = ^rd_data_i[15:12];

    always_comb begin
        tick   = (div_cnt_q == DIV_LAST);
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        // The first tick after reset enters (0,0) instead of stepping past it.
        if (!run_q) begin
            hcnt_d = '0;
            vcnt_d = '0;
        end else if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + CW'(1);
        end else begin
            hcnt_d = hcnt_q + CW'(1);
        end

        nxt_active = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
        fetch_addr = ((hcnt_d == '0) && (vcnt_d == '0)) ? '0 : addr_q;

        cur_active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
        cur_origin = (hcnt_q == '0) && (vcnt_q == '0);
        cur_hs_low = (hcnt_q >= HS_BEG) && (hcnt_q <= HS_END);
        cur_vs_low = (vcnt_q >= VS_BEG) && (vcnt_q <= VS_END);
        cur_vblank = (vcnt_q >= V_ACT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q     <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            run_q         <= 1'b0;
            addr_q        <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            lat_sr_q      <= '0;
            pix_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            vblank_q      <= 1'b0;
        end else begin
            div_cnt_q     <= tick ? '0 : div_cnt_q + DW'(1);
            rd_en_q       <= 1'b0;
            frame_start_q <= 1'b0;
            lat_sr_q      <= (lat_sr_q << 1) | RD_LATENCY'(rd_en_q);

            // Data is valid from RD_LATENCY clks after the strobe; it is sampled on the edge after that.
            if (lat_sr_q[RD_LATENCY-1]) begin
                pix_q <= rd_data_i[11:0];
            end

            if (tick) begin
                run_q  <= 1'b1;
                hcnt_q <= hcnt_d;
                vcnt_q <= vcnt_d;
                if (nxt_active) begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= fetch_addr;
                    addr_q    <= fetch_addr + 19'd1;
                end
                // Pin outputs describe the position fetched one tick ago.
                if (run_q) begin
                    hs_q          <= !cur_hs_low;
                    vs_q          <= !cur_vs_low;
                    vblank_q      <= cur_vblank;
                    rgb_q         <= cur_active ? pix_q : 12'h000;
                    frame_start_q <= cur_origin;
                end
            end
        end
    end

    assign rd_addr_o     = rd_addr_q;
    assign rd_en_o       = rd_en_q;
    assign vga_hs_o      = hs_q;
    assign vga_vs_o      = vs_q;
    assign vga_rgb_o     = rgb_q;
    assign frame_start_o = frame_start_q;
    assign vblank_o      = vblank_q;

endmodule
